// File: rtl/mult_arb_pkg.sv
// Shared constants and helpers for the multiplier arbiter slice.
package mult_arb_pkg;

  // Default fixed-point format of operands and products (Q5.10 in 16 bits)
  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 10;

  // Width of a requester id; at least one bit even for tiny arbiters
  function automatic int id_width(input int num_req);
    int w;
    w = $clog2(num_req);
    return (w < 1) ? 1 : w;
  endfunction

  // Effective pipeline latency: a zero-depth multiplier still registers once
  function automatic int latency(input int delay);
    return (delay < 1) ? 1 : delay;
  endfunction

  // Width of the in-flight counter, able to hold 0..L+1
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester and result bus of the shared multiplier arbiter.
interface mult_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int INPUT_A_WIDTH = DEF_WIDTH,
  parameter int INPUT_B_WIDTH = DEF_WIDTH,
  parameter int OUTPUT_WIDTH  = DEF_WIDTH
) ();

  localparam int ID_WIDTH = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*INPUT_A_WIDTH-1:0] req_a;
  logic [NUM_REQ*INPUT_B_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             res_valid;
  logic [ID_WIDTH-1:0]              res_id;
  logic [OUTPUT_WIDTH-1:0]          res_data;
  logic                             res_ready;
  logic                             idle;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_data, idle
  );

  // Requester / consumer side
  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_data, idle
  );

endinterface

// File: rtl/multiplier.sv
// Pipelined signed fixed-point multiplier with a global stall.
// Product is rescaled to the output fraction by arithmetic shift (truncation)
// and wrapped to the output width. Only the done pipeline is reset.
module multiplier
  import mult_arb_pkg::*;
#(
  parameter int INPUT_A_WIDTH = DEF_WIDTH,
  parameter int INPUT_B_WIDTH = DEF_WIDTH,
  parameter int INPUT_A_FRAC  = DEF_FRAC,
  parameter int INPUT_B_FRAC  = DEF_FRAC,
  parameter int OUTPUT_WIDTH  = DEF_WIDTH,
  parameter int OUTPUT_FRAC   = DEF_FRAC,
  parameter int DELAY         = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            stall,
  input  logic                            en,
  input  logic signed [INPUT_A_WIDTH-1:0] a,
  input  logic signed [INPUT_B_WIDTH-1:0] b,
  output logic signed [OUTPUT_WIDTH-1:0]  out,
  output logic                            done
);

  localparam int PW    = INPUT_A_WIDTH + INPUT_B_WIDTH;
  localparam int SHIFT = INPUT_A_FRAC + INPUT_B_FRAC - OUTPUT_FRAC;
  localparam int L     = latency(DELAY);

  // Drop excess fraction bits (truncate toward -inf) and wrap to output width
  function automatic logic signed [OUTPUT_WIDTH-1:0] fmt_product(
    input logic signed [PW-1:0] p
  );
    logic signed [PW-1:0] s;
    s = p >>> SHIFT;
    return OUTPUT_WIDTH'(s);
  endfunction

  logic signed [PW-1:0]           prod;
  logic signed [OUTPUT_WIDTH-1:0] data_p [L];
  logic                           vld_p  [L];

  assign prod = a * b;

  // Data pipeline: first stage multiplies and formats, rest only delay
  always_ff @(posedge clk) begin
    if (!stall) begin
      data_p[0] <= fmt_product(prod);
      for (int i = 1; i < L; i++) data_p[i] <= data_p[i-1];
    end
  end

  // Completion flag pipeline, synchronously cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) vld_p[i] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= en;
      for (int i = 1; i < L; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign out  = data_p[L-1];
  assign done = vld_p[L-1];

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters.
// An id tag travels alongside each operation so results come back labelled
// with their originator; a stalled result port freezes the whole pipeline.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int INPUT_A_WIDTH = DEF_WIDTH,
  parameter int INPUT_B_WIDTH = DEF_WIDTH,
  parameter int INPUT_A_FRAC  = DEF_FRAC,
  parameter int INPUT_B_FRAC  = DEF_FRAC,
  parameter int OUTPUT_WIDTH  = DEF_WIDTH,
  parameter int OUTPUT_FRAC   = DEF_FRAC,
  parameter int DELAY         = 3
) (
  input  logic          clk,
  input  logic          reset,
  mult_arbiter_if.slave bus
);

  localparam int ID_WIDTH = id_width(NUM_REQ);
  localparam int L        = latency(DELAY);
  localparam int CNT_W    = cnt_width(L);

  logic                            stall;
  logic                            accept;
  logic                            res_hs;
  logic [NUM_REQ-1:0]              grant;
  logic [ID_WIDTH-1:0]             grant_id;
  logic [ID_WIDTH-1:0]             ptr;
  logic signed [INPUT_A_WIDTH-1:0] a_sel;
  logic signed [INPUT_B_WIDTH-1:0] b_sel;
  logic signed [OUTPUT_WIDTH-1:0]  mult_out;
  logic                            mult_done_unused;
  logic                            vld_p [L];
  logic [ID_WIDTH-1:0]             id_p  [L];
  logic [CNT_W-1:0]                inflight;

  assign stall  = bus.res_valid & ~bus.res_ready;
  assign res_hs = bus.res_valid & bus.res_ready;

  // Round-robin search starting at ptr; nothing is granted while stalled
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    idx      = 0;
    if (!stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!accept && bus.req_valid[idx]) begin
          accept      = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = ID_WIDTH'(idx);
        end
      end
    end
  end

  assign bus.req_ready = grant;

  assign a_sel = bus.req_a[int'(grant_id)*INPUT_A_WIDTH +: INPUT_A_WIDTH];
  assign b_sel = bus.req_b[int'(grant_id)*INPUT_B_WIDTH +: INPUT_B_WIDTH];

  // Pointer moves just past the requester that was served
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag pipeline mirrors the multiplier depth; bubbles travel as {0,0}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < L; i++) begin
        vld_p[i] <= 1'b0;
        id_p[i]  <= '0;
      end
    end else if (!stall) begin
      vld_p[0] <= accept;
      id_p[0]  <= accept ? grant_id : '0;
      for (int i = 1; i < L; i++) begin
        vld_p[i] <= vld_p[i-1];
        id_p[i]  <= id_p[i-1];
      end
    end
  end

  // Operations accepted but whose result has not yet been handed off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, res_hs})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  multiplier #(
    .INPUT_A_WIDTH (INPUT_A_WIDTH),
    .INPUT_B_WIDTH (INPUT_B_WIDTH),
    .INPUT_A_FRAC  (INPUT_A_FRAC),
    .INPUT_B_FRAC  (INPUT_B_FRAC),
    .OUTPUT_WIDTH  (OUTPUT_WIDTH),
    .OUTPUT_FRAC   (OUTPUT_FRAC),
    .DELAY         (DELAY)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .stall (stall),
    .en    (accept),
    .a     (a_sel),
    .b     (b_sel),
    .out   (mult_out),
    .done  (mult_done_unused)
  );

  // Product is only presented alongside a valid tag so reset shows zero at once
  assign bus.res_valid = vld_p[L-1];
  assign bus.res_id    = id_p[L-1];
  assign bus.res_data  = vld_p[L-1] ? mult_out : '0;
  assign bus.idle      = (inflight == '0);

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one pipelined fixed-point `multiplier` core among `NUM_REQ` independent requesters. Arbitration is round-robin with a valid/ready handshake per requester. Each request carries a requester ID through a tag pipeline matched to the multiplier latency, so every result returns tagged with its originator. A single result port exerts backpressure by stalling the whole multiplier pipeline. The block sits between the PE-level operand sources and the shared multiply resource.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (≥2)
- `INPUT_A_WIDTH`, 16: operand A width (signed)
- `INPUT_B_WIDTH`, 16: operand B width (signed)
- `INPUT_A_FRAC`, 10: operand A fraction bits
- `INPUT_B_FRAC`, 10: operand B fraction bits
- `OUTPUT_WIDTH`, 16: product width
- `OUTPUT_FRAC`, 10: product fraction bits
- `DELAY`, 3: multiplier pipeline depth; latency `L = max(DELAY,1)`
- `ID_WIDTH`, derived: `max(1, clog2(NUM_REQ))`, not overridable

Ports:
- `clk`, in, 1: clock
- `reset`, in, 1: asynchronous, active-high reset
- `req_valid`, in, NUM_REQ: per-requester request valid
- `req_a`, in, NUM_REQ*INPUT_A_WIDTH: flattened A operands; requester i occupies slice i
- `req_b`, in, NUM_REQ*INPUT_B_WIDTH: flattened B operands; requester i occupies slice i
- `req_ready`, out, NUM_REQ: one-hot or zero grant; reset value 0
- `res_valid`, out, 1: result valid; reset value 0
- `res_id`, out, ID_WIDTH: originating requester; reset value 0
- `res_data`, out, OUTPUT_WIDTH: product in the multiplier's output format; reset value 0
- `res_ready`, in, 1: downstream accepts the result
- `idle`, out, 1: no operation in flight and `res_valid`=0; reset value 1

## Operation
- `stall = res_valid & ~res_ready`. It drives the multiplier `stall` and freezes the tag pipeline, the round-robin pointer and the in-flight counter.
- Grant:
  - Combinational.
  - When `!stall`, pick the first asserted `req_valid` searching from `ptr` upward, wrapping modulo NUM_REQ, and assert that bit of `req_ready`.
  - When `stall` or no request is pending, `req_ready`=0.
- Accept happens on `req_valid[i] & req_ready[i]`:
  - Mux slice i of `req_a`/`req_b` into the multiplier and assert its `en`.
  - Push `{1'b1, i}` into the tag pipeline.
  - `ptr <= (i+1) mod NUM_REQ`.
- With no accept and no stall, push `{0, 0}` into the tag pipeline. Bubbles are not compressed.
- Tag pipeline:
  - L stages of `{valid, id}`, with asynchronous reset to 0.
  - It advances only when `!stall`.
  - `res_valid`/`res_id` come from the last stage.
  - `res_data` is the multiplier `out`.
  - The multiplier `done` is not used for control; the bench asserts `done == res_valid` outside reset.
- `inflight` counter, width clog2(L+2):
  - +1 on accept, −1 on result handshake, unchanged when both occur in the same cycle.
  - `idle = (inflight==0)`.
- Arithmetic (scaling, truncation, wrap) is entirely the multiplier's. This block does not touch data bits.
- Reset mid-operation:
  - All in-flight tags are discarded and `ptr`=0.
  - Outputs go to their reset values asynchronously.
  - The multiplier resets synchronously, so `reset` must be held across ≥1 rising edge.

## Timing
- Request accepted in cycle k → `res_valid`=1 in cycle k+L when no stall occurs in between. Each stalled cycle adds one.
- Throughput: one accept per cycle while `res_ready`=1.
- Output stability: while `res_valid & ~res_ready`, `res_data`/`res_id` are held stable and no new accept occurs.
- Same-cycle handshake: a result handshake and a new accept in the same cycle are both legal.
- `res_valid` depends only on registered state. `req_ready` depends combinationally on `res_ready` through `stall`.

## Structure
- Package `mult_arb_pkg`:
  - `clog2`-based `id_width` function.
  - Default fixed-point format constants (16/10).
- One sub-module instance: `multiplier`, with all format parameters and `DELAY` passed through.
- Arbiter, operand mux, tag pipeline and counter are inline; no further sub-modules.

## Test plan
- Single request:
  - Stimulus: DELAY=3, only requester 2 valid, a=0x0400 (1.0), b=0x0C00 (3.0), `res_ready`=1.
  - Required: `req_ready`=0b0100 in the same cycle; 3 cycles later `res_valid`=1, `res_id`=2, `res_data`=0x0C00; then `idle`=1.
- Round-robin order:
  - Stimulus: all four requesters continuously valid from reset, requester i sending a=b=0x0400·(i+1).
  - Required: grants 0,1,2,3,0,… on consecutive cycles; results with ids in that order, `res_data` for id 1 = 0x1000.
- Fairness:
  - Stimulus: requesters 1 and 3 continuously valid.
  - Required: grants alternate 1,3,1,3; neither requester starves.
- Backpressure:
  - Stimulus: 3 ops in flight, `res_ready` held low for 5 cycles.
  - Required: `req_ready`=0 throughout; `res_data`/`res_id` stable; after release, all 3 results delivered in order with none lost or duplicated; `inflight` returns to 0.
- Reset mid-operation:
  - Stimulus: assert `reset` asynchronously with 2 ops in flight.
  - Required: `res_valid`=0 and `idle`=1 immediately; after release with all four requesters valid, the first grant is requester 0; no stale result appears.
- Minimum depth:
  - Stimulus: DELAY=1 build.
  - Required: result appears the cycle after accept; back-to-back accepts give back-to-back results.
